// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide, one bit per cycle, with sign fix-up afterwards.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  // state  | meaning
  // S_IDLE | waiting for start; MTHI/MTLO handled here
  // S_PREP | take operand magnitudes for signed ops
  // S_RUN  | one multiply/divide bit per cycle
  // S_FIX  | apply result signs, load hi/lo
  // S_DONE | done pulse, results visible
  typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               is_div, is_signed, sa, sb;
  logic [WIDTH-1:0]   abs_a, abs_b, quot, rem;
  logic [WIDTH:0]     mul_sum, div_tmp, div_diff;
  logic [2*WIDTH-1:0] prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    is_div    = op_q[1];
    is_signed = ~op_q[0];
    sa        = is_signed & a_q[WIDTH-1];
    sb        = is_signed & b_q[WIDTH-1];
    abs_a     = sa ? -a_q : a_q;
    abs_b     = sb ? -b_q : b_q;

    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, m_q};
    div_tmp  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff = div_tmp - {1'b0, m_q};

    prod = (sa ^ sb) ? -acc_q : acc_q;
    quot = (sa ^ sb) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem  = sa ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op <= 3'd3) begin
            state_d = S_PREP;
            op_d    = op[1:0];
            a_d     = a;
            b_d     = b;
          end else if (op == 3'd4) begin
            hi_d = a;
          end else if (op == 3'd5) begin
            lo_d = a;
          end
        end
      end
      S_PREP: begin
        // Divide keeps the dividend in the low half; multiply keeps the multiplier there.
        acc_d   = is_div ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
        m_d     = is_div ? abs_b : abs_a;
        cnt_d   = CW'(WIDTH - 1);
        state_d = S_RUN;
      end
      S_RUN: begin
        if (is_div) begin
          if (!div_diff[WIDTH]) acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else                  acc_d = {div_tmp[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          if (acc_q[0]) acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          else          acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        if (!is_div) begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else if (b_q == '0) begin
          hi_d = a_q;
          lo_d = '1;
        end else begin
          hi_d = rem;
          lo_d = quot;
        end
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: arithmetic results, latency, MTHI/MTLO, ignored starts, abort.
module tb_mult_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests = 0;
  int fails = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one op, optionally fires an MTLO mid-run, and checks latency, hold and results.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] va,
                       input logic [31:0] vb, input logic [31:0] exp_hi,
                       input logic [31:0] exp_lo, input bit mid_mtlo);
    int          lat;
    logic        seen;
    logic [31:0] prev_hi, prev_lo;
    prev_hi = hi;
    prev_lo = lo;
    @(negedge clk);
    start = 1'b1; op = o; a = va; b = vb;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      start = 1'b0;
      if (lat == 1) chk({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
      if (lat == 20) begin
        chk({tag, "_hold_hi"}, hi, prev_hi);
        chk({tag, "_hold_lo"}, lo, prev_lo);
      end
      if (mid_mtlo && lat == 5) begin
        start = 1'b1; op = 3'd5; a = 32'h1234_5678;
      end
      seen = done;
    end
    chk({tag, "_latency"}, lat, 32'd35);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
    @(posedge clk); #1;
    chk({tag, "_done_drop"}, {31'd0, done}, 32'd0);
    chk({tag, "_busy_drop"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic seen_done;
    rst_n = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    do_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    do_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    do_op("divu_100_7", 3'd3, 32'd100, 32'd7, 32'd2, 32'h0000_000E, 1'b0);
    do_op("div_neg7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    do_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    do_op("divu_zero", 3'd3, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b0);
    do_op("div_zero_neg", 3'd2, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b0);

    // MTHI / MTLO in IDLE
    @(negedge clk); start = 1'b1; op = 3'd4; a = 32'hAAAA_5555;
    @(posedge clk); #1; start = 1'b0;
    chk("mthi_hi", hi, 32'hAAAA_5555);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    chk("mthi_done", {31'd0, done}, 32'd0);
    chk("mthi_lo_kept", lo, 32'hFFFF_FFFF);
    @(negedge clk); start = 1'b1; op = 3'd5; a = 32'h0BAD_F00D;
    @(posedge clk); #1; start = 1'b0;
    chk("mtlo_lo", lo, 32'h0BAD_F00D);
    chk("mtlo_hi_kept", hi, 32'hAAAA_5555);

    // MTLO while busy must be dropped
    do_op("mult_mtlo_busy", 3'd0, 32'd6, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b1);

    // start during the DONE cycle is ignored
    do_op("multu_pre", 3'd1, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);
    @(negedge clk); start = 1'b1; op = 3'd1; a = 32'd9; b = 32'd9;
    seen_done = 1'b0;
    for (int i = 0; i < 100 && !seen_done; i++) begin
      @(posedge clk); #1; start = 1'b0; seen_done = done;
    end
    chk("done_seen2", {31'd0, seen_done}, 32'd1);
    start = 1'b1; op = 3'd4; a = 32'h5A5A_5A5A;
    @(posedge clk); #1; start = 1'b0;
    chk("done_start_busy", {31'd0, busy}, 32'd0);
    chk("done_start_hi", hi, 32'd0);
    @(posedge clk); #1;
    chk("done_start_busy2", {31'd0, busy}, 32'd0);
    chk("done_start_lo", lo, 32'd81);

    // Abort mid-operation with reset
    @(negedge clk); start = 1'b1; op = 3'd0; a = 32'd7; b = 32'd7;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    chk("abort_no_done", {31'd0, seen_done}, 32'd0);
    do_op("multu_after", 3'd1, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
